if_fetch_ctrl: RTL and testbench

Instruction-fetch controller placed directly around the program-counter register. It consumes the registered PC, issues one instruction-memory read at a time, and buffers returned instructions with their PCs in a small FIFO for the IF/ID stage. It drives the PC register's next-value input: `pc + 4` on an accepted fetch, the EX-stage target on a redirect, otherwise the held value. On redirect it flushes the FIFO and squashes any in-flight response.

---
 rtl/if_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// Fetch controller around the PC register: one outstanding imem read, FIFO to ID.
// Optional IF_BACK2BACK_EN lets a new request issue as the previous response lands.
module if_fetch_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   req_pc;
  fetch_t        fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          can_issue;
  logic          hs;
  logic          push;
  logic          pop;

  assign hs   = imem_req_valid & imem_req_ready;
  assign push = (state == S_WAIT) & imem_rsp_valid & ~redirect_valid;
  assign pop  = id_valid & id_ready & ~redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN: begin
        if (hs) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nx = hs ? S_WAIT : S_RUN;
        end else if (redirect_valid) begin
          state_nx = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_nx = S_RUN;
      end
      default: state_nx = S_RUN;
    endcase
  end

  // Credit check uses start-of-cycle occupancy; pops are not credited.
  always_comb begin
    can_issue = (state == S_RUN) && (count < FULL);
`ifdef IF_BACK2BACK_EN
    if ((state == S_WAIT) && imem_rsp_valid &&
        (count < FULL_M1)) begin
      can_issue = 1'b1;
    end
`endif
    imem_req_valid = rst & can_issue & ~redirect_valid;
    imem_req_addr  = pc_cur;
  end

  always_comb begin
    pc_next = pc_cur;
    if (rst) begin
      if (redirect_valid) begin
        pc_next = redirect_target & 32'hFFFF_FFFC;
      end else if (hs) begin
        pc_next = pc_cur + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc <= '0;
    end else if (hs) begin
      req_pc <= pc_cur;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: req_pc, instr: imem_rsp_data};
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign id_valid = (count != '0);
  assign id_instr = fifo_q[rd_ptr].instr;
  assign id_pc    = fifo_q[rd_ptr].pc;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: PC register, latency-configurable memory
// model and an expected-PC scoreboard checked on every ID pop.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int          errors;
  int          checks;
  int          cyc;
  int          lat;
  bit          pend;
  int          due;
  logic [31:0] pend_addr;
  logic [31:0] exp_q [$];
  int          pop_cyc [$];

  if_fetch_ctrl #(.DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_cur          (pc_cur),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The PC register the controller sits around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_cur <= '0;
    else      pc_cur <= pc_next;
  end

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'd7) ^ 32'h5A5A_0013;
  endfunction

  // Drive this cycle's response, then sample settled outputs at negedge.
  task automatic settle();
    logic [31:0] e;
    imem_rsp_valid = rst && pend && (cyc == due);
    imem_rsp_data  = imem_rsp_valid ? instr_of(pend_addr) : 32'h0;
    @(negedge clk);
    if (imem_rsp_valid) pend = 1'b0;
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      due       = cyc + lat;
      pend_addr = imem_req_addr;
    end
    if (id_valid && id_ready && !redirect_valid) begin
      pop_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h, required no pop", id_pc);
      end else begin
        e = exp_q.pop_front();
        if (id_pc !== e || id_instr !== instr_of(e)) begin
          errors++;
          $display("FAIL sb_pop: got pc %h instr %h, required pc %h instr %h",
                   id_pc, id_instr, e, instr_of(e));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic apply_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    id_ready       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend           = 1'b0;
    lat            = 1;
    exp_q.delete();
    pop_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d left, required 0",
               exp_q.size());
    end
    id_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 ||
        id_pc !== 32'h0 || id_instr !== 32'h0 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: got v%b rq%b pc%h in%h nx%h, required 0s",
               id_valid, imem_req_valid, id_pc, id_instr, pc_next);
    end
    apply_reset();
    settle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 ||
        pc_next !== 32'h4) begin
      errors++;
      $display("FAIL reset_first_req: got rq%b a%h nx%h, required 1 0 4",
               imem_req_valid, imem_req_addr, pc_next);
    end
    tick();
  endtask

  task automatic test_stream();
    int gap;
    int ones;
    apply_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    drain(40);
    checks++;
    if (pop_cyc.size() != 6 || pop_cyc[0] != 2) begin
      errors++;
      $display("FAIL stream_first: got n=%0d c=%0d, required n=6 c=2",
               pop_cyc.size(), pop_cyc.size() ? pop_cyc[0] : -1);
    end
    ones = 0;
    for (int i = 1; i < pop_cyc.size(); i++) begin
      gap = pop_cyc[i] - pop_cyc[i-1];
      if (gap == 1) ones++;
      checks++;
`ifdef IF_BACK2BACK_EN
      if (gap < 1 || gap > 2) begin
`else
      if (gap != 2) begin
`endif
        errors++;
        $display("FAIL stream_gap: got %0d at pop %0d", gap, i);
      end
    end
`ifdef IF_BACK2BACK_EN
    checks++;
    if (ones == 0) begin
      errors++;
      $display("FAIL stream_b2b: got 0 single-cycle gaps, required >0");
    end
`endif
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    repeat (6) cycle();
    settle();
    checks++;
    if (imem_req_valid !== 1'b0 || pc_next !== 32'h8 ||
        pc_cur !== 32'h8) begin
      errors++;
      $display("FAIL fill_stall: got rq%b nx%h pc%h, required 0 8 8",
               imem_req_valid, pc_next, pc_cur);
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL fill_head: got v%b pc%h, required 1 0",
               id_valid, id_pc);
    end
    tick();
    id_ready = 1'b1;
    drain(40);
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    lat = 2;
    repeat (4) cycle();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    settle();
    checks++;
    if (pc_next !== 32'h100 || imem_req_valid !== 1'b0 ||
        id_valid !== 1'b1 || pend !== 1'b1) begin
      errors++;
      $display("FAIL rdw_cycle: got nx%h rq%b v%b pend%b, required 100 0 1 1",
               pc_next, imem_req_valid, id_valid, pend);
    end
    tick();
    redirect_valid = 1'b0;
    settle();
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 ||
        imem_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rdw_drop: got v%b rq%b rsp%b, required 0 0 1",
               id_valid, imem_req_valid, imem_rsp_valid);
    end
    tick();
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    id_ready = 1'b1;
    drain(40);
  endtask

  task automatic test_redirect_rsp();
    apply_reset();
    id_ready = 1'b1;
    cycle();
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    settle();
    checks++;
    if (pc_next !== 32'h200 || imem_req_valid !== 1'b0 ||
        imem_rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rdr_cycle: got nx%h rq%b rsp%b, required 200 0 1",
               pc_next, imem_req_valid, imem_rsp_valid);
    end
    tick();
    redirect_valid = 1'b0;
    settle();
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL rdr_restart: got v%b rq%b a%h, required 0 1 200",
               id_valid, imem_req_valid, imem_req_addr);
    end
    tick();
    drain(40);
  endtask

  task automatic test_wrap();
    apply_reset();
    id_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    settle();
    checks++;
    if (pc_next !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_redir: got %h, required fffffffc", pc_next);
    end
    tick();
    redirect_valid = 1'b0;
    settle();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC ||
        pc_next !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: got rq%b a%h nx%h, required 1 fffffffc 0",
               imem_req_valid, imem_req_addr, pc_next);
    end
    tick();
    drain(40);
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    repeat (2) cycle();
    settle();
    checks++;
    if (id_valid !== 1'b1 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got v%b rq%b, required 1 1",
               id_valid, imem_req_valid);
    end
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 ||
        id_pc !== 32'h0 || id_instr !== 32'h0 || pc_next !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got v%b rq%b pc%h in%h nx%h, required 0s",
               id_valid, imem_req_valid, id_pc, id_instr, pc_next);
    end
    apply_reset();
    id_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    drain(40);
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    cyc             = 0;
    lat             = 1;
    pend            = 1'b0;
    due             = 0;
    pend_addr       = '0;
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    id_ready        = 1'b0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
